wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two sources.
  - The in-order pipeline writeback result, which is the normal stream.
  - The multi-cycle unit (MCU) result, such as multiply/divide, which uses a valid/ready handshake.
- Fixed priority goes to the pipeline, with an anti-starvation counter that forces an MCU grant.
- Handles same-register write-after-write (WAW) collisions and suppresses writes to $r0.
- Sits between the writeback stage and the register file; the register-file write signals are registered (1-cycle latency).

Parameters:
- DATA_W, 8, data width of the register file.
- ADDR_W, 3, register address width (8 registers; address 0 is hardwired zero).
- MAX_WAIT, 4, number of consecutive refused cycles with MCU valid before the MCU is forced through (range 1..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pipe_we  in  1  pipeline writeback request
- pipe_waddr  in  ADDR_W  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline result
- pipe_stall  out  1  combinational; pipeline must hold its writeback stage this cycle
- mcu_valid  in  1  MCU result available
- mcu_waddr  in  ADDR_W  MCU destination register
- mcu_wdata  in  DATA_W  MCU result
- mcu_ready  out  1  combinational; MCU result consumed this cycle (written or discarded)
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  ADDR_W  registered write address
- rf_wdata  out  DATA_W  registered write data
- mcu_drop  out  1  registered 1-cycle pulse; MCU result was discarded due to a WAW collision

Behaviour:
- Effective requests:
  - p_req = pipe_we && pipe_waddr != 0.
  - m_req = mcu_valid && mcu_waddr != 0.
- MCU with address 0: mcu_ready = 1 in the same cycle, no write, no drop pulse, wait_cnt cleared.
- wait_cnt has width clog2(MAX_WAIT+1) and is saturating. force = (wait_cnt == MAX_WAIT).
- Decision each cycle, evaluated in this priority order:
  1. WAW: p_req && m_req && pipe_waddr == mcu_waddr.
     - Pipeline granted; mcu_ready = 1 (MCU result discarded); mcu_drop = 1 next cycle; wait_cnt cleared.
     - This rule applies even when force = 1.
  2. force && m_req.
     - MCU granted; mcu_ready = 1; pipe_stall = p_req; wait_cnt cleared.
  3. p_req.
     - Pipeline granted; mcu_ready = 0.
     - If m_req: wait_cnt increments, saturating at MAX_WAIT. Otherwise wait_cnt is cleared.
  4. m_req only.
     - MCU granted; mcu_ready = 1; wait_cnt cleared.
  5. Neither request.
     - No write; wait_cnt cleared.
- pipe_stall is asserted only in rule 2.
  - A stalled pipeline re-presents the same request next cycle; it is granted then because wait_cnt is 0.
- A pipeline request to address 0 never stalls and never writes.
- Granted source: at the next posedge, rf_we = 1 and rf_waddr/rf_wdata take that source's address/data.
- No grant: rf_we = 0 at the next posedge. rf_waddr/rf_wdata are also cleared to 0 so the write port is defined when idle.
- MCU handshake:
  - mcu_valid/addr/data must remain stable until mcu_ready = 1.
  - The arbiter does not depend on mcu_valid deasserting between results; back-to-back results are allowed.
- Reset:
  - While reset is high, rf_we = 0, rf_waddr = 0, rf_wdata = 0, mcu_drop = 0 and wait_cnt = 0 immediately (asynchronous).
  - While reset is high, mcu_ready = 0 and pipe_stall = 0 (combinationally gated).
  - A reset asserted mid-starvation discards the accumulated count; an MCU request pending across reset restarts at wait_cnt = 0.
- No combinational path from any rf_* output back to any input.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with pipe_we = 1, addr 3, data 0x5A -> rf_we, rf_waddr, rf_wdata drop to 0 before the next edge; mcu_ready = 0 and pipe_stall = 0 throughout.
- Pipeline only: pipe_we = 1, addr 2, data 0x11 -> next cycle rf_we = 1, rf_waddr = 2, rf_wdata = 0x11; idle cycle after -> rf_we = 0, rf_waddr = 0, rf_wdata = 0.
- Starvation (MAX_WAIT = 4): pipe_we = 1 to addr 1 every cycle; mcu_valid = 1, addr 5, data 0xC3 from cycle 0.
  - Cycles 0-3: mcu_ready = 0.
  - Cycle 4: mcu_ready = 1, pipe_stall = 1; cycle 5: rf_waddr = 5, rf_wdata = 0xC3.
  - Cycle 5: pipeline granted; cycle 6: rf_waddr = 1.
- WAW: pipe_we = 1 and mcu_valid = 1 both to addr 4 (pipe 0x22, MCU 0x99) -> mcu_ready = 1, pipe_stall = 0; next cycle rf_wdata = 0x22 and mcu_drop = 1 for exactly one cycle. Repeat with wait_cnt = MAX_WAIT -> same result.
- $r0 suppression: pipe_we = 1 to addr 0 with mcu_valid = 1 to addr 6 -> MCU granted immediately, no stall. mcu_valid = 1 to addr 0 alone -> mcu_ready = 1, rf_we = 0, mcu_drop = 0.
- Back-to-back MCU: mcu_valid held high for 3 results (addrs 2, 3, 7) with no pipeline traffic -> mcu_ready = 1 each cycle; rf writes 2, 3, 7 on consecutive cycles.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Write-port arbitration bundle: pipeline writeback, MCU handshake and the
// registered register-file write port.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              pipe_stall;

  logic              mcu_valid;
  logic [ADDR_W-1:0] mcu_waddr;
  logic [DATA_W-1:0] mcu_wdata;
  logic              mcu_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mcu_drop;

  // Requesters / register-file side.
  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output mcu_valid, mcu_waddr, mcu_wdata,
    input  pipe_stall, mcu_ready,
    input  rf_we, rf_waddr, rf_wdata, mcu_drop
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  mcu_valid, mcu_waddr, mcu_wdata,
    output pipe_stall, mcu_ready,
    output rf_we, rf_waddr, rf_wdata, mcu_drop
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline has fixed priority, the MCU is
// forced through after MAX_WAIT refused cycles; WAW collisions drop the MCU.
module wb_port_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   bus
);

  localparam int                CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_MCU
  } grant_e;

  logic              p_req;
  logic              m_req;
  logic              waw;
  logic              force_mcu;
  grant_e            grant;

  logic              mcu_ready_c;
  logic              pipe_stall_c;

  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              mcu_drop_q, mcu_drop_d;

  // Writes to $r0 are not requests at all.
  assign p_req     = bus.pipe_we   && (bus.pipe_waddr != '0);
  assign m_req     = bus.mcu_valid && (bus.mcu_waddr  != '0);
  assign waw       = p_req && m_req && (bus.pipe_waddr == bus.mcu_waddr);
  assign force_mcu = (wait_q == WAIT_MAX);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant        = GNT_NONE;
    mcu_ready_c  = bus.mcu_valid && (bus.mcu_waddr == '0);
    pipe_stall_c = 1'b0;
    mcu_drop_d   = 1'b0;
    wait_d       = '0;

    if (waw) begin
      // The later pipeline write supersedes the MCU result, even when forced.
      grant       = GNT_PIPE;
      mcu_ready_c = 1'b1;
      mcu_drop_d  = 1'b1;
    end else if (force_mcu && m_req) begin
      grant        = GNT_MCU;
      mcu_ready_c  = 1'b1;
      pipe_stall_c = p_req;
    end else if (p_req) begin
      grant = GNT_PIPE;
      if (m_req) begin
        wait_d = force_mcu ? wait_q : wait_q + 1'b1;
      end
    end else if (m_req) begin
      grant       = GNT_MCU;
      mcu_ready_c = 1'b1;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    unique case (grant)
      GNT_PIPE: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.pipe_waddr;
        rf_wdata_d = bus.pipe_wdata;
      end
      GNT_MCU: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.mcu_waddr;
        rf_wdata_d = bus.mcu_wdata;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      mcu_drop_q <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mcu_drop_q <= mcu_drop_d;
    end
  end

  // Handshake outputs are held inactive while reset is asserted.
  assign bus.mcu_ready  = mcu_ready_c  && !reset;
  assign bus.pipe_stall = pipe_stall_c && !reset;

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.mcu_drop = mcu_drop_q;

endmodule
